pcap_irq_queue: RTL and testbench

Parametrised successor to the single-channel PCAP IRQ status path (one IRQ_STATUS word carrying IRQ_FLAGS and SMPL_COUNT). It accepts buffer-completion events from NCHAN DMA/capture channels and arbitrates them round-robin into a DEPTH-entry status FIFO. It presents the FIFO head as a 32-bit pop-on-read status register and drives a coalesced interrupt (level threshold or timeout). It sits between the PCAP DMA engines and the AXI register slave, so the bench can check every armed/completed/sample-count event in order.

---
 rtl/pcap_irq_queue.sv | 150 +++++++++++++++
 tb/tb_pcap_irq_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcap_irq_queue.sv
// Multi-channel PCAP IRQ status queue: round-robin event arbiter, DEPTH-entry
// status FIFO with a pop-on-read head word, and threshold/timeout IRQ coalescing.
module pcap_irq_queue #(
    parameter int unsigned NCHAN  = 4,
    parameter int unsigned CHAN_W = 2,
    parameter int unsigned FLAG_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LVL_W  = 5
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic [NCHAN-1:0]         evt_valid_i,
    output logic [NCHAN-1:0]         evt_ready_o,
    input  logic [NCHAN*FLAG_W-1:0]  evt_flags_i,
    input  logic [NCHAN*CNT_W-1:0]   evt_count_i,
    input  logic                     rd_strobe_i,
    output logic [31:0]              rd_data_o,
    input  logic                     clear_i,
    input  logic [LVL_W-1:0]         irq_thresh_i,
    input  logic [15:0]              irq_timeout_i,
    output logic                     irq_o,
    output logic [LVL_W-1:0]         level_o
);

    localparam int unsigned ENTRY_W = FLAG_W + CHAN_W + CNT_W;
    localparam int unsigned PTR_W   = LVL_W - 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CHAN_W-1:0]  rr_q, rr_d;
    logic               irq_q, irq_d;
    logic [15:0]        timer_q, timer_d;

    logic [NCHAN-1:0]   gnt_oh;
    logic [CHAN_W-1:0]  gnt_idx;
    logic [ENTRY_W-1:0] push_entry;
    logic [LVL_W-1:0]   thresh_eff;
    logic               full, empty, push, pop, tmo_hit;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);

    // First requester at or after rr, wrapping; constant indexing keeps it NCHAN-agnostic.
    always_comb begin
        int unsigned c;
        c       = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            c = (32'(rr_q) + i) % NCHAN;
            for (int unsigned j = 0; j < NCHAN; j++) begin
                if (gnt_oh == '0 && j == c && evt_valid_i[j]) begin
                    gnt_oh[j] = 1'b1;
                    gnt_idx   = CHAN_W'(j);
                end
            end
        end
    end

    always_comb begin
        push_entry = '0;
        for (int unsigned j = 0; j < NCHAN; j++) begin
            if (gnt_oh[j]) begin
                push_entry = {evt_count_i[j*CNT_W +: CNT_W], CHAN_W'(j),
                              evt_flags_i[j*FLAG_W +: FLAG_W]};
            end
        end
    end

    assign evt_ready_o = (!clear_i && !full) ? gnt_oh : '0;
    assign push        = |evt_ready_o;
    assign pop         = rd_strobe_i && !empty && !clear_i;
    assign thresh_eff  = (irq_thresh_i == '0) ? LVL_W'(1) : irq_thresh_i;
    assign tmo_hit     = (irq_timeout_i != '0) && !empty &&
                         (({1'b0, timer_q} + 17'd1) == {1'b0, irq_timeout_i});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rr_d     = rr_q;
        irq_d    = irq_q;
        timer_d  = timer_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            irq_d    = 1'b0;
            timer_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rr_d     = CHAN_W'((32'(gnt_idx) + 1) % NCHAN);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
            if (empty || irq_q) begin
                timer_d = '0;
            end else if (timer_q != '1) begin
                timer_d = timer_q + 16'd1;
            end
            if (level_d == '0) begin
                irq_d = 1'b0;
            end else if (!irq_q && (level_d >= thresh_eff || tmo_hit)) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rr_q     <= '0;
            irq_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rr_q     <= rr_d;
            irq_q    <= irq_d;
            timer_q  <= timer_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (resetn_i && push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (!empty) begin
            rd_data_o[ENTRY_W-1:0] = mem_q[rd_ptr_q];
            rd_data_o[31]          = 1'b1;
        end
    end

    assign irq_o   = irq_q;
    assign level_o = level_q;

endmodule

// File: tb/tb_pcap_irq_queue.sv
// Bench for pcap_irq_queue: directed vector table, corner-case sequences,
// then random traffic against a queue-based reference model.
module tb_pcap_irq_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  evt_valid, evt_ready;
    logic [31:0] evt_flags;
    logic [63:0] evt_count;
    logic        rd_strobe, clr;
    logic [31:0] rd_data;
    logic [4:0]  thresh, level;
    logic [15:0] timeout;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fixed_flags  = 32'h33_81_22_11;
    logic [63:0] fixed_counts = 64'hFFFF_0123_1111_0AAA;

    always #5 clk = ~clk;

    pcap_irq_queue #(
        .NCHAN(4), .CHAN_W(2), .FLAG_W(8), .CNT_W(16), .DEPTH(16), .LVL_W(5)
    ) dut (
        .clk_i(clk), .resetn_i(resetn),
        .evt_valid_i(evt_valid), .evt_ready_o(evt_ready),
        .evt_flags_i(evt_flags), .evt_count_i(evt_count),
        .rd_strobe_i(rd_strobe), .rd_data_o(rd_data),
        .clear_i(clr), .irq_thresh_i(thresh), .irq_timeout_i(timeout),
        .irq_o(irq), .level_o(level)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        rd;
        logic        clr;
        logic [3:0]  exp_ready;
        logic [31:0] exp_data;
        logic        exp_irq;
        logic [4:0]  exp_lvl;
    } vec_t;

    vec_t tbl[8];

    // Reference model state
    logic [31:0] mq[$];
    int          m_rr, m_timer;
    logic        m_irq;

    function automatic logic [31:0] pack(input logic [15:0] cnt, input int ch, input logic [7:0] fl);
        logic [1:0] c2;
        c2 = ch[1:0];
        return 32'h8000_0000 | (32'(cnt) << 10) | (32'(c2) << 8) | 32'(fl);
    endfunction

    function automatic logic [31:0] exp_word(input int c);
        return pack(fixed_counts[c*16 +: 16], c, fixed_flags[c*8 +: 8]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        evt_valid = '0;
        rd_strobe = 1'b0;
        clr       = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        evt_flags = fixed_flags;
        evt_count = fixed_counts;
        thresh    = 5'd0;
        timeout   = 16'd0;
        do_reset();

        chk("reset level", 32'(level), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        chk("reset data", rd_data, 32'd0);
        chk("reset ready", 32'(evt_ready), 32'd0);

        // Table: thresh 0 (acts as 1), timeout off
        tbl[0] = '{4'b0100, 1'b0, 1'b0, 4'b0100, exp_word(2), 1'b1, 5'd1};
        tbl[1] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 32'd0,       1'b0, 5'd0};
        tbl[2] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 32'd0,       1'b0, 5'd0};
        tbl[3] = '{4'b0001, 1'b0, 1'b0, 4'b0001, exp_word(0), 1'b1, 5'd1};
        tbl[4] = '{4'b1010, 1'b1, 1'b0, 4'b0010, exp_word(1), 1'b1, 5'd1};
        tbl[5] = '{4'b1000, 1'b0, 1'b0, 4'b1000, exp_word(1), 1'b1, 5'd2};
        tbl[6] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 32'd0,       1'b0, 5'd0};
        tbl[7] = '{4'b0110, 1'b0, 1'b0, 4'b0010, exp_word(1), 1'b1, 5'd1};
        for (int i = 0; i < 8; i++) begin
            evt_valid = tbl[i].valid;
            rd_strobe = tbl[i].rd;
            clr       = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d ready", i), 32'(evt_ready), 32'(tbl[i].exp_ready));
            step();
            chk($sformatf("tbl%0d data", i), rd_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d irq", i), 32'(irq), 32'(tbl[i].exp_irq));
            chk($sformatf("tbl%0d level", i), 32'(level), 32'(tbl[i].exp_lvl));
        end

        // Round-robin with all channels requesting
        do_reset();
        thresh    = 5'd16;
        evt_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr grant%0d", i), 32'(evt_ready), 32'(1) << (i % 4));
            step();
        end
        evt_valid = '0;
        chk("rr level", 32'(level), 32'd5);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr drain%0d", i), rd_data, exp_word(i % 4));
            rd_strobe = 1'b1;
            step();
            rd_strobe = 1'b0;
        end
        chk("rr drained level", 32'(level), 32'd0);

        // Full / backpressure
        do_reset();
        thresh    = 5'd16;
        evt_valid = 4'b0001;
        for (int i = 0; i < 16; i++) step();
        #1;
        chk("full level", 32'(level), 32'd16);
        chk("full ready", 32'(evt_ready), 32'd0);
        chk("full irq", 32'(irq), 32'd1);
        rd_strobe = 1'b1;
        #1;
        chk("full pop ready", 32'(evt_ready), 32'd0);
        step();
        rd_strobe = 1'b0;
        chk("full after pop", 32'(level), 32'd15);
        #1;
        chk("full refill ready", 32'(evt_ready), 32'd1);
        step();
        chk("full refilled", 32'(level), 32'd16);
        evt_valid = '0;

        // Coalescing by level threshold
        do_reset();
        thresh  = 5'd4;
        timeout = 16'd0;
        for (int i = 0; i < 3; i++) begin
            evt_valid = 4'b0001;
            step();
            evt_valid = '0;
            step();
            chk($sformatf("thr4 irq after %0d", i + 1), 32'(irq), 32'd0);
        end
        evt_valid = 4'b0001;
        step();
        evt_valid = '0;
        chk("thr4 irq after 4", 32'(irq), 32'd1);
        chk("thr4 level", 32'(level), 32'd4);

        // Coalescing by timeout
        do_reset();
        thresh    = 5'd16;
        timeout   = 16'd10;
        evt_valid = 4'b0001;
        step();
        evt_valid = '0;
        chk("tmo k0", 32'(irq), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("tmo k%0d", k), 32'(irq), (k >= 10) ? 32'd1 : 32'd0);
        end
        timeout = 16'd0;

        // clear_i beats a same-cycle push and pop
        do_reset();
        thresh    = 5'd1;
        evt_valid = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        chk("clr pre level", 32'(level), 32'd5);
        chk("clr pre irq", 32'(irq), 32'd1);
        clr       = 1'b1;
        rd_strobe = 1'b1;
        #1;
        chk("clr ready", 32'(evt_ready), 32'd0);
        step();
        clr       = 1'b0;
        rd_strobe = 1'b0;
        evt_valid = '0;
        chk("clr level", 32'(level), 32'd0);
        chk("clr irq", 32'(irq), 32'd0);
        chk("clr data", rd_data, 32'd0);
        step();
        chk("clr retained", 32'(level), 32'd0);

        // Reset mid-burst, rr returns to 0
        do_reset();
        thresh    = 5'd1;
        evt_valid = 4'hF;
        for (int i = 0; i < 7; i++) step();
        evt_valid = '0;
        chk("rst pre level", 32'(level), 32'd7);
        chk("rst pre irq", 32'(irq), 32'd1);
        resetn = 1'b0;
        step();
        chk("rst level", 32'(level), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        chk("rst data", rd_data, 32'd0);
        chk("rst ready", 32'(evt_ready), 32'd0);
        resetn    = 1'b1;
        evt_valid = 4'hF;
        #1;
        chk("rst first grant", 32'(evt_ready), 32'd1);
        step();
        chk("rst first entry", rd_data, exp_word(0));
        evt_valid = '0;

        // Random traffic against the reference model
        do_reset();
        mq.delete();
        m_rr    = 0;
        m_irq   = 1'b0;
        m_timer = 0;
        thresh  = 5'd4;
        timeout = 16'd6;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          g, rdpct, old_n, old_t, new_n, thr;
            logic        old_irq, fire;
            logic [3:0]  exp_rdy;
            rdpct     = ((cyc / 500) % 2 == 1) ? 70 : 25;
            evt_valid = 4'($urandom);
            evt_flags = $urandom;
            evt_count = {$urandom, $urandom};
            rd_strobe = ($urandom % 100) < rdpct;
            clr       = ($urandom % 100) < 2;
            resetn    = ($urandom % 100) >= 1;
            if ($urandom % 150 == 0) thresh = 5'($urandom_range(0, 17));
            if ($urandom % 150 == 0) timeout = 16'($urandom_range(0, 24));
            #1;
            g = -1;
            if (!clr && mq.size() < 16) begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m_rr + k) % 4;
                    if (g < 0 && evt_valid[c]) g = c;
                end
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            chk("rnd ready", 32'(evt_ready), 32'(exp_rdy));
            chk("rnd data", rd_data, (mq.size() > 0) ? mq[0] : 32'd0);
            chk("rnd irq", 32'(irq), 32'(m_irq));
            chk("rnd level", 32'(level), 32'(mq.size()));
            @(posedge clk);
            if (!resetn) begin
                mq.delete();
                m_rr    = 0;
                m_irq   = 1'b0;
                m_timer = 0;
            end else if (clr) begin
                mq.delete();
                m_irq   = 1'b0;
                m_timer = 0;
            end else begin
                old_n   = mq.size();
                old_t   = m_timer;
                old_irq = m_irq;
                if (rd_strobe && old_n > 0) void'(mq.pop_front());
                if (g >= 0) begin
                    mq.push_back(pack(evt_count[g*16 +: 16], g, evt_flags[g*8 +: 8]));
                    m_rr = (g + 1) % 4;
                end
                new_n = mq.size();
                thr   = (thresh == 0) ? 1 : int'(thresh);
                fire  = (timeout != 0) && (old_n > 0) && (old_t + 1 == int'(timeout));
                if (new_n == 0) m_irq = 1'b0;
                else if (!old_irq && (new_n >= thr || fire)) m_irq = 1'b1;
                m_timer = (old_n == 0 || old_irq) ? 0 : ((old_t < 65535) ? old_t + 1 : 65535);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
